lea_lcd_ctrl: RTL
=================

// Module: lea_lcd_ctrl
// PURPOSE
//  Display-side endpoint of the LEA control unit's 3-bit LCD message index (LCD_addr).
//  Initialises an HD44780-compatible 16x2 character LCD over an 8-bit parallel bus.
//  Rewrites both lines from an internal message ROM whenever the index changes.
//  Sits between the LEA CU and the board LCD pins; it is a write-only device driver.
// PARAMETERS
//  PWRUP_WAIT_CYC  750000  cycles idle after reset before the first command (15 ms @50 MHz)
//  E_PULSE_CYC     12      cycles lcd_e is held high per byte
//  CMD_WAIT_CYC    2000    cycles after E falls before the next byte (40 us)
//  CLR_WAIT_CYC    82000   cycles after E falls following the 0x01 clear command (1.64 ms)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   synchronous, active-high reset
//  LCD_addr      in   3   message index from the LEA CU (0..6 used, 7 = blank)
//  lcd_e         out  1   LCD enable strobe
//  lcd_rs        out  1   0 = command, 1 = character data
//  lcd_rw        out  1   tied to 0 (write only)
//  lcd_data      out  8   LCD data bus
//  busy          out  1   high while initialising or refreshing
//  refresh_done  out  1   one-cycle pulse when the last character of line 2 is written
// BEHAVIOUR
//  Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, busy=1, refresh_done=0.
//  Reset returns the FSM to PWRUP from any state, including mid-byte; lcd_e drops the
//    same edge.
//  LCD_addr is registered every cycle into addr_q; shown_q holds the index last displayed.
//  FSM: PWRUP -> INIT -> L1_ADDR -> L1_CHR -> L2_ADDR -> L2_CHR -> IDLE.
//   PWRUP: count PWRUP_WAIT_CYC cycles.
//   INIT: commands 0x38, 0x0C, 0x06, 0x01 in order; the wait after 0x01 is CLR_WAIT_CYC.
//   L1_ADDR: command 0x80. L1_CHR: 16 data bytes of ROM[idx] line 1, column 0..15.
//   L2_ADDR: command 0xC0. L2_CHR: 16 data bytes of line 2.
//   IDLE: busy=0. If addr_q != shown_q, go to L1_ADDR with busy=1 on the next edge.
//  idx is captured from addr_q on entry to L1_ADDR and held for the whole refresh.
//    shown_q <= idx when refresh_done pulses.
//  Byte write: rs and data are set at the cycle E rises and held stable through E high
//    and the whole wait. Then E is high for E_PULSE_CYC cycles, low for the wait count,
//    and the next byte follows. Counters are down-counters, so each phase is exactly
//    N cycles.
//  After reset a refresh of the current index always follows INIT, without comparing
//    against shown_q.
//  A reset refresh is 38 bytes; an index-change refresh is 34 bytes. No clear command
//    is issued, so every cell is overwritten.
//  LCD_addr changing mid-refresh does not abort the refresh. On return to IDLE the
//    latest addr_q is compared against shown_q.
//  Multiple changes during a refresh collapse to the final value.
//  A change that returns to the value being shown causes no second refresh.
//  Index 7 displays 32 spaces (0x20).
//  Latency: LCD_addr change at edge k -> addr_q at k+1 -> busy=1 and first E rise at k+2.
//  ROM lines, each padded with spaces to 16 characters:
//    0 "LEA CIPHER" / "*:ENC  #:NEXT"
//    1 "INPUT PLAINTEXT" / "#:OK"
//    2 "INPUT KEY" / "#:OK"
//    3 "ENCRYPT SUCCESS" / "#:SHOW"
//    4 "CIPHERTEXT" / "*:DECRYPT"
//    5 "INPUT KEY (DEC)" / "#:OK"
//    6 "DECRYPT SUCCESS" / "*:RESTART"
// CONFIGURATION
//  LEA_LCD_HEX_EN defined:
//   - Adds port disp_word (in, 32) and samples it when idx is captured.
//   - For indices 4 and 6, line 2 columns 0..7 show disp_word as 8 uppercase hex
//     digits, MSB first; columns 8..15 are spaces.
//   - All other indices are unchanged.
//  LEA_LCD_HEX_EN undefined: no disp_word port; line 2 always comes from the ROM.
// STRUCTURE
//  Package lea_lcd_pkg holds:
//   - the FSM state encoding;
//   - command constants CMD_FUNC_SET=8'h38, CMD_DISP_ON=8'h0C, CMD_ENTRY=8'h06,
//     CMD_CLEAR=8'h01, CMD_LINE1=8'h80, CMD_LINE2=8'hC0;
//   - the function msg_char(idx, line, col) returning the ROM byte.
//  Sub-module lea_lcd_byte_wr: one-byte strobe and wait sequencer.
//   - Inputs: start, rs, data, long_wait.
//   - Output: done, a one-cycle pulse at the end of the wait.
//   - Drives lcd_e, lcd_rs and lcd_data.
// TESTING
//  The bench overrides PWRUP_WAIT_CYC=10, E_PULSE_CYC=2, CMD_WAIT_CYC=4, CLR_WAIT_CYC=8.
//  The bench models the LCD by capturing (rs, data) on each falling edge of lcd_e.
//  1 Reset, LCD_addr=0
//    -> first E rise 10 cycles after reset release, rs=0 data=0x38;
//    -> 38 bytes total: 38,0C,06,01,80,"LEA CIPHER      ",C0,"*:ENC  #:NEXT   ";
//    -> busy falls and refresh_done pulses once.
//  2 IDLE, LCD_addr 0->2
//    -> busy=1 two cycles later;
//    -> 34 bytes: 80,"INPUT KEY       ",C0,"#:OK            ".
//  3 LCD_addr 1->3 then ->5 during refresh of 1
//    -> refresh of 1 completes intact, then exactly one refresh of 5.
//  4 LCD_addr 7
//    -> 32 data bytes of 0x20; lcd_rw stays 0 throughout.
//  5 rst pulsed while lcd_e=1 mid-L1_CHR
//    -> next edge lcd_e=0, busy=1; a full 38-byte sequence restarts.
//  6 LEA_LCD_HEX_EN, idx 4, disp_word=32'hDEADBEEF
//    -> line 2 = "DEADBEEF        ".

Source files
------------

// File: rtl/lea_lcd_pkg.sv
// Shared types, LCD command bytes and the message ROM for the LEA LCD driver.
// Optional hex readout of a data word is enabled with LEA_LCD_HEX_EN.
package lea_lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT,
    ST_L1_ADDR,
    ST_L1_CHR,
    ST_L2_ADDR,
    ST_L2_CHR,
    ST_IDLE
  } lcd_state_e;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PULSE,
    WR_WAIT
  } wr_phase_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;
  localparam logic [7:0] CHR_SPACE    = 8'h20;

  // ROM byte for message idx, line (0/1), column 0..15
  function automatic logic [7:0] msg_char(
    input logic [2:0] idx,
    input logic       line,
    input logic [3:0] col
  );
    logic [127:0] txt;
    unique case ({idx, line})
      {3'd0, 1'b0}: txt = {"LEA CIPHER", {6{CHR_SPACE}}};
      {3'd0, 1'b1}: txt = {"*:ENC  #:NEXT", {3{CHR_SPACE}}};
      {3'd1, 1'b0}: txt = {"INPUT PLAINTEXT", CHR_SPACE};
      {3'd1, 1'b1}: txt = {"#:OK", {12{CHR_SPACE}}};
      {3'd2, 1'b0}: txt = {"INPUT KEY", {7{CHR_SPACE}}};
      {3'd2, 1'b1}: txt = {"#:OK", {12{CHR_SPACE}}};
      {3'd3, 1'b0}: txt = {"ENCRYPT SUCCESS", CHR_SPACE};
      {3'd3, 1'b1}: txt = {"#:SHOW", {10{CHR_SPACE}}};
      {3'd4, 1'b0}: txt = {"CIPHERTEXT", {6{CHR_SPACE}}};
      {3'd4, 1'b1}: txt = {"*:DECRYPT", {7{CHR_SPACE}}};
      {3'd5, 1'b0}: txt = {"INPUT KEY (DEC)", CHR_SPACE};
      {3'd5, 1'b1}: txt = {"#:OK", {12{CHR_SPACE}}};
      {3'd6, 1'b0}: txt = {"DECRYPT SUCCESS", CHR_SPACE};
      {3'd6, 1'b1}: txt = {"*:RESTART", {7{CHR_SPACE}}};
      default:      txt = {16{CHR_SPACE}};
    endcase
    return txt[{4'd15 - col, 3'b000} +: 8];
  endfunction

  // Uppercase ASCII hex digit
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/lea_lcd_byte_wr.sv
// One-byte LCD write: E strobe of E_PULSE_CYC cycles, then a settle wait.
// rs/data are held from the E rise until the next byte is started.
module lea_lcd_byte_wr
  import lea_lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 12,
  parameter int CMD_WAIT_CYC = 2000,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int M1 = (E_PULSE_CYC > CMD_WAIT_CYC) ?
                      E_PULSE_CYC : CMD_WAIT_CYC;
  localparam int MX = (M1 > CLR_WAIT_CYC) ? M1 : CLR_WAIT_CYC;
  localparam int CW = $clog2(MX + 1);

  wr_phase_e     phase_q;
  logic [CW-1:0] cnt_q;
  logic          long_q;
  logic          e_q;
  logic          rs_q;
  logic [7:0]    data_q;

  // Strobe/wait sequencer; a new start always wins and raises E this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= WR_IDLE;
      cnt_q   <= '0;
      long_q  <= 1'b0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else if (start) begin
      phase_q <= WR_PULSE;
      cnt_q   <= CW'(E_PULSE_CYC - 1);
      long_q  <= long_wait;
      e_q     <= 1'b1;
      rs_q    <= rs;
      data_q  <= data;
    end else begin
      unique case (phase_q)
        WR_PULSE: begin
          if (cnt_q == '0) begin
            e_q     <= 1'b0;
            phase_q <= WR_WAIT;
            cnt_q   <= long_q ? CW'(CLR_WAIT_CYC - 1)
                              : CW'(CMD_WAIT_CYC - 1);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WR_WAIT: begin
          if (cnt_q == '0) phase_q <= WR_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign done     = (phase_q == WR_WAIT) && (cnt_q == '0);
  assign lcd_e    = e_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;

endmodule

// File: rtl/lea_lcd_ctrl.sv
// HD44780 16x2 driver: power-up init, then rewrites both lines on index change.
// Define LEA_LCD_HEX_EN to add disp_word and show it in hex for indices 4 and 6.
module lea_lcd_ctrl
  import lea_lcd_pkg::*;
#(
  parameter int PWRUP_WAIT_CYC = 750000,
  parameter int E_PULSE_CYC    = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLR_WAIT_CYC   = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  LCD_addr,
`ifdef LEA_LCD_HEX_EN
  input  logic [31:0] disp_word,
`endif
  output logic        lcd_e,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic        busy,
  output logic        refresh_done
);

  localparam int PW = $clog2(PWRUP_WAIT_CYC + 1);

  lcd_state_e    state_q, state_d;
  logic [3:0]    pos_q, pos_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    addr_q;
  logic [2:0]    shown_q;
  logic [PW-1:0] pwr_q;
  logic          busy_q;
  logic          rdone_q;
  logic          cap;
  logic          go;
  logic          fin;
  logic          wr_done;
  logic          wr_rs;
  logic          wr_long;
  logic [7:0]    wr_data;
  logic [7:0]    chr;
`ifdef LEA_LCD_HEX_EN
  logic [31:0]   hex_q;
`endif

  // Index input is sampled every cycle, reset or not
  always_ff @(posedge clk) begin
    addr_q <= LCD_addr;
  end

  // Next state: advance one byte per completed write
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cap     = 1'b0;
    go      = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      ST_PWRUP: begin
        if (pwr_q == '0) begin
          go      = 1'b1;
          state_d = ST_INIT;
          pos_d   = 4'd0;
        end
      end
      ST_INIT: begin
        if (wr_done) begin
          go = 1'b1;
          if (pos_q == 4'd3) begin
            state_d = ST_L1_ADDR;
            pos_d   = 4'd0;
            cap     = 1'b1;
          end else begin
            pos_d = pos_q + 4'd1;
          end
        end
      end
      ST_L1_ADDR: begin
        if (wr_done) begin
          go      = 1'b1;
          state_d = ST_L1_CHR;
          pos_d   = 4'd0;
        end
      end
      ST_L1_CHR: begin
        if (wr_done) begin
          go = 1'b1;
          if (pos_q == 4'd15) state_d = ST_L2_ADDR;
          else                pos_d   = pos_q + 4'd1;
        end
      end
      ST_L2_ADDR: begin
        if (wr_done) begin
          go      = 1'b1;
          state_d = ST_L2_CHR;
          pos_d   = 4'd0;
        end
      end
      ST_L2_CHR: begin
        if (wr_done) begin
          if (pos_q == 4'd15) begin
            state_d = ST_IDLE;
            fin     = 1'b1;
          end else begin
            go    = 1'b1;
            pos_d = pos_q + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        if (addr_q != shown_q) begin
          go      = 1'b1;
          state_d = ST_L1_ADDR;
          pos_d   = 4'd0;
          cap     = 1'b1;
        end
      end
      default: state_d = ST_PWRUP;
    endcase
  end

  assign idx_d = cap ? addr_q : idx_q;

  // Character for the byte about to be written
  always_comb begin
    chr = msg_char(idx_d, state_d == ST_L2_CHR, pos_d);
`ifdef LEA_LCD_HEX_EN
    if (state_d == ST_L2_CHR &&
        (idx_d == 3'd4 || idx_d == 3'd6)) begin
      chr = pos_d[3] ? CHR_SPACE
          : hex_ascii(hex_q[{~pos_d[2:0], 2'b00} +: 4]);
    end
`endif
  end

  // Byte to launch for the state being entered
  always_comb begin
    wr_rs   = 1'b0;
    wr_long = 1'b0;
    wr_data = CMD_FUNC_SET;
    unique case (state_d)
      ST_INIT: begin
        unique case (pos_d[1:0])
          2'd0:    wr_data = CMD_FUNC_SET;
          2'd1:    wr_data = CMD_DISP_ON;
          2'd2:    wr_data = CMD_ENTRY;
          default: begin
            wr_data = CMD_CLEAR;
            wr_long = 1'b1;
          end
        endcase
      end
      ST_L1_ADDR: wr_data = CMD_LINE1;
      ST_L2_ADDR: wr_data = CMD_LINE2;
      ST_L1_CHR, ST_L2_CHR: begin
        wr_rs   = 1'b1;
        wr_data = chr;
      end
      default: ;
    endcase
  end

  // Controller state and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PWRUP;
      pos_q   <= 4'd0;
      idx_q   <= 3'd0;
      shown_q <= 3'd0;
      pwr_q   <= PW'(PWRUP_WAIT_CYC - 1);
      busy_q  <= 1'b1;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d != ST_IDLE);
      rdone_q <= fin;
      if (fin) shown_q <= idx_q;
      if (state_q == ST_PWRUP && pwr_q != '0)
        pwr_q <= pwr_q - 1'b1;
    end
  end

`ifdef LEA_LCD_HEX_EN
  // Data word is frozen together with the index
  always_ff @(posedge clk) begin
    if (rst)      hex_q <= 32'h0;
    else if (cap) hex_q <= disp_word;
  end
`endif

  lea_lcd_byte_wr #(
    .E_PULSE_CYC  (E_PULSE_CYC),
    .CMD_WAIT_CYC (CMD_WAIT_CYC),
    .CLR_WAIT_CYC (CLR_WAIT_CYC)
  ) u_wr (
    .clk       (clk),
    .rst       (rst),
    .start     (go),
    .rs        (wr_rs),
    .data      (wr_data),
    .long_wait (wr_long),
    .done      (wr_done),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_data  (lcd_data)
  );

  assign lcd_rw       = 1'b0;
  assign busy         = busy_q;
  assign refresh_done = rdone_q;

endmodule
